// File: rtl/fifo_tx_feeder_pkg.sv
// fifo_tx_feeder_pkg: shared FSM encoding and default widths for the TX FIFO feeder.
package fifo_tx_feeder_pkg;
   typedef enum logic [1:0] {IDLE = 2'b00, SEND = 2'b01, BUSY = 2'b10} feed_state_t;
   localparam int DEF_DATA_WIDTH     = 8;
   localparam int DEF_CNT_WIDTH      = 8;
   localparam int DEF_TIMEOUT_CYCLES = 64;
endpackage

// File: rtl/feed_timeout_cnt.sv
// feed_timeout_cnt: clearable saturating counter; tc is high once the count reaches MAX.
module feed_timeout_cnt
   import fifo_tx_feeder_pkg::*;
#(
   parameter int MAX = DEF_TIMEOUT_CYCLES - 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tc
);
   localparam int W = (MAX < 2) ? 1 : $clog2(MAX + 1);
   localparam logic [W-1:0] MAX_V = W'(MAX);
   logic [W-1:0] cnt;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else if (clr) cnt <= '0;
      else if (en && !tc) cnt <= cnt + 1'b1;
   assign tc = cnt == MAX_V;
endmodule

// File: rtl/fifo_tx_feeder.sv
// fifo_tx_feeder: pops the async TX FIFO one byte at a time and hands it to the UART.
// Optional SEND abort after TIMEOUT_CYCLES is compiled in with FIFO_TX_FEEDER_TIMEOUT_EN.
module fifo_tx_feeder
   import fifo_tx_feeder_pkg::*;
#(
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int CNT_WIDTH      = DEF_CNT_WIDTH,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  empty,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic                  r_inc,
   input  logic                  tx_busy,
   output logic [DATA_WIDTH-1:0] tx_data,
   output logic                  tx_valid,
   output logic [CNT_WIDTH-1:0]  tx_cnt,
   output logic                  tx_err
);
   feed_state_t state, state_nxt;
   logic pop, accept, timeout;
   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 2");
   end
`ifdef FIFO_TX_FEEDER_TIMEOUT_EN
   logic timeout_tc;
   // Counter is held clear outside SEND, so every SEND entry starts from zero.
   feed_timeout_cnt #(.MAX(TIMEOUT_CYCLES - 1)) u_timeout (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (state != SEND),
      .en   (state == SEND),
      .tc   (timeout_tc)
   );
   assign timeout = state == SEND && !tx_busy && timeout_tc;
`else
   assign timeout = 1'b0;
`endif
   always_comb begin
      pop = rst_n && !empty && (state == IDLE || (state == BUSY && !tx_busy));
      accept = state == SEND && tx_busy;
      state_nxt = state;
      if (pop) state_nxt = SEND;
      else if (accept) state_nxt = BUSY;
      else if (timeout || (state == BUSY && !tx_busy)) state_nxt = IDLE;
   end
   assign r_inc = pop;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state    <= IDLE;
         tx_data  <= '0;
         tx_valid <= 1'b0;
         tx_cnt   <= '0;
         tx_err   <= 1'b0;
      end else begin
         state  <= state_nxt;
         tx_err <= timeout;
         if (pop) begin
            tx_data  <= rd_data;
            tx_valid <= 1'b1;
         end else if (accept || timeout) tx_valid <= 1'b0;
         if (accept) tx_cnt <= tx_cnt + 1'b1;
      end
endmodule

// File: tb/tb_fifo_tx_feeder.sv
// tb_fifo_tx_feeder: directed bench with a small FIFO model; a CNT_WIDTH=2 twin checks counter wrap.
module tb_fifo_tx_feeder;
   logic       clk = 1'b0;
   logic       rst_n, tx_busy, empty, r_inc, tx_valid, tx_err;
   logic       w_r_inc, w_valid, w_err;
   logic [7:0] rd_data, tx_data, tx_cnt, w_data;
   logic [1:0] w_cnt;
   logic [7:0] mem [0:15];
   logic [3:0] wp = '0, rp = '0;
   int         errors = 0, checks = 0, n_pop = 0, p0;

   always #5 clk = ~clk;
   assign empty   = wp == rp;
   assign rd_data = mem[rp];
   always @(posedge clk) if (r_inc) begin
      rp <= rp + 1'b1;
      n_pop <= n_pop + 1;
   end

   fifo_tx_feeder #(.DATA_WIDTH(8), .CNT_WIDTH(8), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rst_n(rst_n), .empty(empty), .rd_data(rd_data), .r_inc(r_inc),
      .tx_busy(tx_busy), .tx_data(tx_data), .tx_valid(tx_valid), .tx_cnt(tx_cnt), .tx_err(tx_err)
   );
   fifo_tx_feeder #(.DATA_WIDTH(8), .CNT_WIDTH(2), .TIMEOUT_CYCLES(8)) dut_wrap (
      .clk(clk), .rst_n(rst_n), .empty(empty), .rd_data(rd_data), .r_inc(w_r_inc),
      .tx_busy(tx_busy), .tx_data(w_data), .tx_valid(w_valid), .tx_cnt(w_cnt), .tx_err(w_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] b);
      mem[wp] = b;
      wp = wp + 1'b1;
   endtask

   task automatic wait_valid();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!tx_valid && n < 20);
      chk("wait_valid", tx_valid, 1);
   endtask

   task automatic accept();
      tx_busy = 1'b1;
      @(negedge clk);
      tx_busy = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      tx_busy = 1'b0;
      push(8'h11);
      repeat (3) @(negedge clk);
      chk("rst_r_inc", r_inc, 0);
      chk("rst_valid", tx_valid, 0);
      chk("rst_cnt", tx_cnt, 0);
      chk("rst_err", tx_err, 0);
      chk("rst_data", tx_data, 0);
      rst_n = 1'b1;
      #1 chk("rel_r_inc", r_inc, 1);
      @(negedge clk);
      chk("rel_valid", tx_valid, 1);
      chk("rel_data", tx_data, 8'h11);
      chk("rel_r_inc_once", r_inc, 0);
      accept();
      chk("rel_accept_valid", tx_valid, 0);
      chk("rel_cnt", tx_cnt, 1);
      chk("rel_wrap_cnt", w_cnt, 1);

      @(negedge clk);
      p0 = n_pop;
      push(8'hA5);
      #1 chk("single_r_inc", r_inc, 1);
      repeat (4) begin
         @(negedge clk);
         chk("single_valid", tx_valid, 1);
         chk("single_data", tx_data, 8'hA5);
         chk("single_no_pop", r_inc, 0);
      end
      accept();
      chk("single_cnt", tx_cnt, 2);
      chk("single_accept_valid", tx_valid, 0);
      chk("single_pops", n_pop - p0, 1);

      @(negedge clk);
      p0 = n_pop;
      for (int i = 1; i <= 4; i++) push(8'(i));
      for (int i = 0; i < 4; i++) begin
         wait_valid();
         chk("b2b_data", tx_data, i + 1);
         tx_busy = 1'b1;
         repeat (10) @(negedge clk);
         chk("b2b_cnt", tx_cnt, 3 + i);
         chk("b2b_wrap_cnt", w_cnt, (3 + i) % 4);
         chk("b2b_busy_valid", tx_valid, 0);
         tx_busy = 1'b0;
         #1 chk("b2b_direct_pop", r_inc, i < 3);
      end
      chk("b2b_pops", n_pop - p0, 4);

      @(negedge clk);
      push(8'h5A);
      wait_valid();
      repeat (7) @(negedge clk);
      chk("stall_valid", tx_valid, 1);
      chk("stall_err", tx_err, 0);
      @(negedge clk);
`ifdef FIFO_TX_FEEDER_TIMEOUT_EN
      chk("timeout_err", tx_err, 1);
      chk("timeout_valid", tx_valid, 0);
      chk("timeout_cnt", tx_cnt, 6);
      @(negedge clk);
      chk("timeout_err_pulse", tx_err, 0);
`else
      chk("no_timeout_valid", tx_valid, 1);
      chk("no_timeout_err", tx_err, 0);
      chk("no_timeout_data", tx_data, 8'h5A);
      accept();
      chk("no_timeout_cnt", tx_cnt, 7);
`endif

      @(negedge clk);
      push(8'h77);
      push(8'h88);
      wait_valid();
      chk("mid_data", tx_data, 8'h77);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", tx_valid, 0);
      chk("mid_rst_data", tx_data, 0);
      chk("mid_rst_r_inc", r_inc, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk("mid_rel_r_inc", r_inc, 1);
      wait_valid();
      chk("mid_next_data", tx_data, 8'h88);
      accept();
      chk("mid_cnt", tx_cnt, 1);
      @(negedge clk);
      chk("mid_no_resend", r_inc, 0);
      chk("mid_idle_valid", tx_valid, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/fifo_tx_feeder.md
# fifo_tx_feeder

Read-side consumer for the asynchronous FIFO in the transmit path. It runs in the read-clock domain and watches the FIFO empty flag. It pops one byte at a time and presents it to the UART transmitter with a valid/busy handshake, so system-domain writes drain to the serial line without byte loss or duplication.

## Interface
Parameters:
- DATA_WIDTH, 8, width of FIFO read data and TX data
- CNT_WIDTH, 8, width of the sent-byte counter
- TIMEOUT_CYCLES, 64, cycles allowed in SEND before abort (only with timeout compiled in); minimum 2

Ports:
- CLK  in  1  read/TX-domain clock
- RST  in  1  asynchronous active-low reset
- EMPTY  in  1  FIFO empty flag, synchronous to CLK
- RD_DATA  in  DATA_WIDTH  FIFO head word, valid whenever EMPTY=0
- R_INC  out  1  FIFO pop strobe, one cycle per byte
- TX_BUSY  in  1  UART transmitter busy (high while shifting a frame)
- TX_DATA  out  DATA_WIDTH  byte presented to UART, registered
- TX_VALID  out  1  TX_DATA valid, registered
- TX_CNT  out  CNT_WIDTH  bytes accepted by UART, wraps modulo 2^CNT_WIDTH
- TX_ERR  out  1  one-cycle pulse when a byte is dropped on timeout

## Operation
- Reset value of every output is 0: R_INC, TX_DATA, TX_VALID, TX_CNT and TX_ERR. The FSM resets to IDLE.
- FSM states: IDLE, SEND, BUSY.
- IDLE:
  - If EMPTY=0: R_INC=1 this cycle (combinational from state and EMPTY), capture RD_DATA into TX_DATA, set TX_VALID, go to SEND.
  - Otherwise stay in IDLE with R_INC=0.
- SEND:
  - TX_VALID=1 and TX_DATA held stable.
  - On TX_BUSY=1: clear TX_VALID, increment TX_CNT, go to BUSY.
- BUSY:
  - Wait for TX_BUSY=0.
  - When TX_BUSY=0 and EMPTY=0: pop and load as in IDLE, go directly to SEND (back-to-back path).
  - When TX_BUSY=0 and EMPTY=1: go to IDLE.
- R_INC is asserted only in the IDLE→SEND and BUSY→SEND transitions, exactly one cycle per byte.
- R_INC is never asserted while EMPTY=1.
- TX_CNT wraps from 2^CNT_WIDTH−1 to 0 with no flag.
- If TX_BUSY is already high on entry to SEND, the byte counts as accepted on that cycle.
- RST asserted mid-operation: state returns to IDLE and outputs clear immediately. A popped but unsent byte is lost, because the FIFO pointer has already advanced.

## Timing
- EMPTY falls with sample edge n in IDLE: R_INC is high during cycle n, and TX_VALID/TX_DATA are registered at edge n+1.
- FIFO-to-UART latency is 1 cycle.
- TX_BUSY seen high at edge k: TX_VALID=0 after edge k, and TX_CNT is updated at edge k.
- Back-to-back throughput is one byte per UART frame + 1 cycle.
- TX_ERR is a single-cycle pulse, registered.

## Configuration
- Macro: FIFO_TX_FEEDER_TIMEOUT_EN.
- Defined:
  - A counter runs while in SEND.
  - If TX_BUSY stays 0 for TIMEOUT_CYCLES cycles, TX_VALID clears, TX_ERR pulses for 1 cycle, the byte is dropped, TX_CNT is unchanged, and the FSM goes to IDLE.
  - The counter clears on every SEND entry.
- Undefined:
  - SEND waits indefinitely.
  - TX_ERR is tied to 0 and the counter logic is absent.

## Structure
- Shared package fifo_tx_feeder_pkg holds:
  - the state encodings (IDLE=2'b00, SEND=2'b01, BUSY=2'b10)
  - the default widths
  - the TIMEOUT_CYCLES default
- Sub-module feed_timeout_cnt provides a clearable saturating counter with a terminal-count output. It is instantiated only under FIFO_TX_FEEDER_TIMEOUT_EN.

## Test plan
- Reset: hold RST=0 with EMPTY=0 → R_INC, TX_VALID, TX_CNT and TX_ERR all stay 0. Release RST → R_INC pulses on the next cycle.
- Single byte: RD_DATA=0xA5, EMPTY drops for 1 cycle → exactly one R_INC. TX_DATA=0xA5 with TX_VALID=1 until TX_BUSY=1, then TX_CNT=1.
- Back-to-back: 4 bytes 0x01..0x04 queued, UART busy 10 cycles per frame → 4 R_INC pulses, bytes delivered in order, no IDLE visit between frames, TX_CNT=4.
- Wrap: CNT_WIDTH=2, send 5 bytes → TX_CNT sequence 1,2,3,0,1.
- Mid-operation reset: assert RST while in SEND → TX_VALID=0 immediately. After release, the next FIFO byte is sent and the lost byte is not re-sent.
- Timeout (macro on, TIMEOUT_CYCLES=8): TX_BUSY held 0 → TX_ERR pulses 8 cycles after SEND entry, TX_CNT unchanged, FSM back in IDLE. With the macro off, TX_VALID stays high.
